// File: rtl/ahb_pkg.sv
// AHB-Lite shared definitions for the command master, slave and bench.
// Only the two transfer types this bus segment uses are encoded.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_t;

    function automatic logic is_nonseq(input htrans_t t);
        return t == HTRANS_NONSEQ;
    endfunction

endpackage

// File: rtl/ahb_cmd_master.sv
// AHB-Lite master: valid/ready commands to NONSEQ single transfers.
// Address phase of the next transfer overlaps data phase of the current one.
module ahb_cmd_master
    import ahb_pkg::*;
#(
    parameter int addrWidth     = 8,
    parameter int dataWidth     = 32,
    parameter int timeoutCycles = 16
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_write,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 hselx,
    output logic [1:0]           htrans,
    output logic [addrWidth-1:0] haddr,
    output logic                 hwrite,
    output logic [dataWidth-1:0] hwdata,
    input  logic                 hready,
    input  logic [dataWidth-1:0] hrdata,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int CW = $clog2(timeoutCycles + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(timeoutCycles);

    htrans_t              r_htrans;
    logic                 r_hselx;
    logic [addrWidth-1:0] r_haddr;
    logic                 r_hwrite;
    logic [dataWidth-1:0] r_wdata_hold;
    logic [dataWidth-1:0] r_hwdata;
    logic                 r_dp_valid;
    logic                 r_dp_write;
    logic                 r_rsp_valid;
    logic                 r_rsp_write;
    logic [dataWidth-1:0] r_rsp_rdata;
    logic [CW-1:0]        r_to_cnt;
    logic                 r_timeout_err;

    logic          w_accept;
    logic          w_ap_done;
    logic          w_dp_done;
    logic          w_busy;
    logic          w_to_inc;
    logic [CW-1:0] w_to_next;

    assign w_accept  = cmd_valid & hready;
    assign w_ap_done = hready & is_nonseq(r_htrans);
    assign w_dp_done = hready & r_dp_valid;
    assign w_busy    = is_nonseq(r_htrans) | r_dp_valid;
    assign w_to_inc  = w_busy & ~hready & (r_to_cnt != TO_MAX);
    assign w_to_next = r_to_cnt + 1'b1;

    // Address phase: a low hready freezes everything presented on the bus
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_htrans     <= HTRANS_IDLE;
            r_hselx      <= 1'b0;
            r_haddr      <= '0;
            r_hwrite     <= 1'b0;
            r_wdata_hold <= '0;
        end else if (w_accept) begin
            r_htrans     <= HTRANS_NONSEQ;
            r_hselx      <= 1'b1;
            r_haddr      <= cmd_addr;
            r_hwrite     <= cmd_write;
            r_wdata_hold <= cmd_wdata;
        end else if (hready) begin
            r_htrans     <= HTRANS_IDLE;
            r_hselx      <= 1'b0;
            r_haddr      <= '0;
            r_hwrite     <= 1'b0;
        end
    end

    // Data phase: dp_valid stays set when a new address phase lands on the same edge
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_hwdata   <= '0;
        end else if (hready) begin
            r_dp_valid <= w_ap_done;
            if (w_ap_done) begin
                r_dp_write <= r_hwrite;
                r_hwdata   <= r_hwrite ? r_wdata_hold : '0;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_dp_done;
            if (w_dp_done) begin
                r_rsp_write <= r_dp_write;
                r_rsp_rdata <= r_dp_write ? '0 : hrdata;
            end
        end
    end

    // Stall watchdog only flags; the transfer is left to finish
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (hready) begin
                r_to_cnt <= '0;
            end else if (w_to_inc) begin
                r_to_cnt <= w_to_next;
            end
            if (w_to_inc && (w_to_next == TO_MAX)) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign cmd_ready   = hready;
    assign htrans      = r_htrans;
    assign hselx       = r_hselx;
    assign haddr       = r_haddr;
    assign hwrite      = r_hwrite;
    assign hwdata      = r_hwdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_write   = r_rsp_write;
    assign rsp_rdata   = r_rsp_rdata;
    assign busy        = w_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Bench for ahb_cmd_master: behavioural AHB slave memory plus a
// response scoreboard fed by the stimulus thread.
module tb_ahb_cmd_master;
    import ahb_pkg::*;

    typedef struct {
        logic        w;
        logic [31:0] d;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        hselx;
    logic [1:0]  htrans;
    logic [7:0]  haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nrsp = 0;
    int last_rsp_cyc = 0;
    int prev_rsp_cyc = 0;
    exp_t q[$];

    ahb_cmd_master #(
        .addrWidth(8),
        .dataWidth(32),
        .timeoutCycles(16)
    ) dut (
        .hclk(hclk),
        .hresetn(hresetn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .hselx(hselx),
        .htrans(htrans),
        .haddr(haddr),
        .hwrite(hwrite),
        .hwdata(hwdata),
        .hready(hready),
        .hrdata(hrdata),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 hclk = ~hclk;

    always @(posedge hclk) cyc <= cyc + 1;

    // Slave memory; unwritten locations read as 0x5A5A00<addr>
    logic [31:0]  mem [256];
    logic [255:0] mem_v;
    logic         s_dp;
    logic         s_wr;
    logic [7:0]   s_addr;

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            s_dp   <= 1'b0;
            s_wr   <= 1'b0;
            s_addr <= '0;
            mem_v  <= '0;
        end else if (hready) begin
            if (s_dp && s_wr) mem_v[s_addr] <= 1'b1;
            s_dp   <= hselx && (htrans == HTRANS_NONSEQ);
            s_wr   <= hwrite;
            s_addr <= haddr;
        end
    end

    always @(posedge hclk) begin
        if (hresetn && hready && s_dp && s_wr) mem[s_addr] <= hwdata;
    end

    assign hrdata = (s_dp && !s_wr)
                  ? (mem_v[s_addr] ? mem[s_addr] : (32'h5A5A_0000 | 32'(s_addr)))
                  : 32'h0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, act, exp);
        end
    endtask

    always @(negedge hclk) begin
        if (rsp_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp got w=%0b d=%h exp none",
                         rsp_write, rsp_rdata);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_write", 32'(rsp_write), 32'(e.w));
                chk("rsp_rdata", rsp_rdata, e.d);
            end
            prev_rsp_cyc = last_rsp_cyc;
            last_rsp_cyc = cyc;
            nrsp++;
        end
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic cmd(input logic w, input logic [7:0] a,
                       input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
    endtask

    task automatic push(input logic w, input logic [31:0] d);
        exp_t e;
        e.w = w;
        e.d = d;
        q.push_back(e);
    endtask

    task automatic wait_rsp(input int tgt);
        int k = 0;
        while (nrsp < tgt && k < 60) begin
            tick();
            k++;
        end
        chk("rsp_count", 32'(nrsp), 32'(tgt));
    endtask

    initial begin
        int n0;
        int acc;
        hresetn = 1'b0;
        hready  = 1'b1;
        idle();
        repeat (2) tick();
        chk("rst_htrans", 32'(htrans), 32'(HTRANS_IDLE));
        chk("rst_hselx", 32'(hselx), 0);
        chk("rst_haddr", 32'(haddr), 0);
        chk("rst_hwrite", 32'(hwrite), 0);
        chk("rst_hwdata", hwdata, 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        hresetn = 1'b1;
        tick();

        // single write
        n0 = nrsp;
        cmd(1'b1, 8'h10, 32'hDEADBEEF);
        push(1'b1, 32'h0);
        tick();
        acc = cyc;
        idle();
        chk("w1_htrans", 32'(htrans), 32'(HTRANS_NONSEQ));
        chk("w1_haddr", 32'(haddr), 32'h10);
        chk("w1_hwrite", 32'(hwrite), 1);
        chk("w1_hselx", 32'(hselx), 1);
        chk("w1_busy", 32'(busy), 1);
        tick();
        chk("w1_hwdata", hwdata, 32'hDEADBEEF);
        chk("w1_htrans_idle", 32'(htrans), 32'(HTRANS_IDLE));
        wait_rsp(n0 + 1);
        chk("w1_latency", 32'(last_rsp_cyc - acc), 2);

        // write then read back-to-back
        n0 = nrsp;
        cmd(1'b1, 8'h04, 32'h12345678);
        push(1'b1, 32'h0);
        tick();
        cmd(1'b0, 8'h04, 32'h0);
        push(1'b0, 32'h12345678);
        tick();
        idle();
        wait_rsp(n0 + 2);
        chk("b2b_spacing", 32'(last_rsp_cyc - prev_rsp_cyc), 1);

        // read with 3 wait states in data phase
        n0 = nrsp;
        cmd(1'b0, 8'h20, 32'h0);
        push(1'b0, 32'h5A5A_0020);
        tick();
        acc = cyc;
        idle();
        tick();
        hready = 1'b0;
        tick();
        chk("ws_cmd_ready", 32'(cmd_ready), 0);
        chk("ws_htrans", 32'(htrans), 32'(HTRANS_IDLE));
        chk("ws_hwdata", hwdata, 32'h0);
        chk("ws_busy", 32'(busy), 1);
        tick();
        tick();
        chk("ws_no_rsp_yet", 32'(nrsp), 32'(n0));
        hready = 1'b1;
        wait_rsp(n0 + 1);
        chk("ws_latency", 32'(last_rsp_cyc - acc), 5);

        // streaming writes then reads
        n0 = nrsp;
        for (int i = 0; i < 4; i++) begin
            cmd(1'b1, 8'(i), 32'(i + 1));
            push(1'b1, 32'h0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            cmd(1'b0, 8'(i), 32'h0);
            push(1'b0, 32'(i + 1));
            tick();
        end
        idle();
        wait_rsp(n0 + 8);
        chk("stream_spacing", 32'(last_rsp_cyc - prev_rsp_cyc), 1);

        // timeout with address phase stalled
        n0 = nrsp;
        cmd(1'b0, 8'h30, 32'h0);
        push(1'b0, 32'h5A5A_0030);
        tick();
        idle();
        hready = 1'b0;
        repeat (15) tick();
        chk("to_before", 32'(timeout_err), 0);
        tick();
        chk("to_set", 32'(timeout_err), 1);
        hready = 1'b1;
        tick();
        tick();
        chk("to_sticky", 32'(timeout_err), 1);
        wait_rsp(n0 + 1);

        // reset during write data phase
        n0 = nrsp;
        cmd(1'b1, 8'h08, 32'hCAFEF00D);
        tick();
        idle();
        tick();
        chk("rm_hwdata", hwdata, 32'hCAFEF00D);
        hresetn = 1'b0;
        #1;
        chk("rm_hwdata_rst", hwdata, 32'h0);
        chk("rm_htrans", 32'(htrans), 32'(HTRANS_IDLE));
        chk("rm_haddr", 32'(haddr), 0);
        chk("rm_busy", 32'(busy), 0);
        chk("rm_timeout", 32'(timeout_err), 0);
        chk("rm_rsp_valid", 32'(rsp_valid), 0);
        repeat (3) tick();
        chk("rm_no_rsp", 32'(nrsp), 32'(n0));
        hresetn = 1'b1;
        tick();
        cmd(1'b0, 8'h08, 32'h0);
        push(1'b0, 32'h5A5A_0008);
        tick();
        idle();
        wait_rsp(n0 + 1);

        repeat (3) tick();
        chk("sb_empty", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule
